// File: rtl/npu_host_driver.sv
// npu_host_driver: host-side load/read master for the NPU bus; `define NPU_DRV_TIMEOUT_EN adds a ready-wait timeout
module npu_host_driver #(
  parameter int DW       = 32,
  parameter int WCNT_W   = 12,
  parameter int OUT_LAT  = 1,
  parameter int WAIT_MAX = 4095
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        cfg_layers,
  input  logic [4:0]        cfg_in,
  input  logic [4:0]        cfg_h1,
  input  logic [4:0]        cfg_h2,
  input  logic [4:0]        cfg_out,
  input  logic              cfg_act,
  input  logic [WCNT_W-1:0] cfg_num_w,
  input  logic              src_valid,
  input  logic [DW-1:0]     src_data,
  output logic              src_ready,
  output logic              npu_we,
  output logic              npu_oe,
  output logic [DW-1:0]     npu_data_o,
  output logic              npu_data_oe,
  input  logic [DW-1:0]     npu_data_i,
  input  logic              npu_ready,
  output logic              res_valid,
  output logic [DW-1:0]     res_data,
  output logic [4:0]        res_idx,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CFG  = 3'd1;
  localparam logic [2:0] S_WGT  = 3'd2;
  localparam logic [2:0] S_INP  = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4;
  localparam logic [2:0] S_READ = 3'd5;
  if (OUT_LAT < 1 || WAIT_MAX < 1) begin : g_bad_param
    $error("npu_host_driver: OUT_LAT and WAIT_MAX must be >= 1");
  end
  logic [2:0]        state;
  logic [WCNT_W-1:0] cnt;
  logic [1:0]        l_layers;
  logic [4:0]        l_in, l_h1, l_h2, l_out;
  logic              l_act;
  logic [WCNT_W-1:0] l_num_w;
  logic [DW-1:0]     data_q;
  logic              res_last;
  logic [DW-1:0]     cfg_word;
  logic [DW-1:0]     drv;
  logic              in_stream;
  logic              last_w, last_in;
  logic              rd_take, rd_last;
  logic [WCNT_W-1:0] rd_off;
`ifdef NPU_DRV_TIMEOUT_EN
  localparam int WW = $clog2(WAIT_MAX + 1);
  logic [WW-1:0] wcnt;
`else
  assign err = 1'b0;
`endif
  // bus drive, handshake and read-window decode from the current phase
  always_comb begin
    cfg_word  = cnt[2:0] == 3'd0 ? DW'(l_layers) :
                cnt[2:0] == 3'd1 ? DW'(l_in) :
                cnt[2:0] == 3'd2 ? DW'(l_h1) :
                cnt[2:0] == 3'd3 ? DW'(l_h2) :
                cnt[2:0] == 3'd4 ? DW'(l_out) : DW'(l_act);
    in_stream   = state == S_WGT || state == S_INP;
    src_ready   = in_stream;
    npu_we      = state == S_CFG || (in_stream && src_valid);
    drv         = state == S_CFG ? cfg_word : src_data;
    npu_data_o  = npu_we ? drv : data_q;
    npu_data_oe = state == S_CFG || in_stream;
    npu_oe      = state == S_READ;
    busy        = state != S_IDLE;
    last_w      = cnt == l_num_w - 1'b1;
    last_in     = cnt == WCNT_W'(l_in);
    rd_off      = cnt - WCNT_W'(OUT_LAT);
    rd_take     = state == S_READ && cnt >= WCNT_W'(OUT_LAT);
    rd_last     = rd_take && rd_off == WCNT_W'(l_out);
  end
  // phase sequencing, config latch, held bus value and result capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      l_layers  <= '0;
      l_in      <= '0;
      l_h1      <= '0;
      l_h2      <= '0;
      l_out     <= '0;
      l_act     <= 1'b0;
      l_num_w   <= '0;
      data_q    <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_idx   <= '0;
      res_last  <= 1'b0;
      done      <= 1'b0;
`ifdef NPU_DRV_TIMEOUT_EN
      wcnt      <= '0;
      err       <= 1'b0;
`endif
    end else begin
      res_valid <= 1'b0;
      done      <= res_valid & res_last;
      if (npu_we) data_q <= drv;
      case (state)
        S_IDLE: if (start) begin
          state    <= S_CFG;
          cnt      <= '0;
          l_layers <= cfg_layers;
          l_in     <= cfg_in;
          l_h1     <= cfg_h1;
          l_h2     <= cfg_h2;
          l_out    <= cfg_out;
          l_act    <= cfg_act;
          l_num_w  <= cfg_num_w;
`ifdef NPU_DRV_TIMEOUT_EN
          err      <= 1'b0;
`endif
        end
        S_CFG: begin
          cnt   <= cnt == WCNT_W'(5) ? '0 : cnt + 1'b1;
          state <= cnt == WCNT_W'(5) ? S_WGT : S_CFG;
        end
        S_WGT: if (src_valid) begin
          cnt   <= last_w ? '0 : cnt + 1'b1;
          state <= last_w ? S_INP : S_WGT;
        end
        S_INP: if (src_valid) begin
          cnt   <= last_in ? '0 : cnt + 1'b1;
          state <= last_in ? S_WAIT : S_INP;
        end
`ifdef NPU_DRV_TIMEOUT_EN
        S_WAIT: if (npu_ready) begin
          state <= S_READ;
          cnt   <= '0;
          wcnt  <= '0;
        end else if (wcnt == WW'(WAIT_MAX - 1)) begin
          state <= S_IDLE;
          wcnt  <= '0;
          err   <= 1'b1;
        end else begin
          wcnt  <= wcnt + 1'b1;
        end
`else
        S_WAIT: if (npu_ready) begin
          state <= S_READ;
          cnt   <= '0;
        end
`endif
        S_READ: begin
          cnt <= cnt + 1'b1;
          if (rd_take) begin
            res_valid <= 1'b1;
            res_data  <= npu_data_i;
            res_idx   <= rd_off[4:0];
            res_last  <= rd_last;
          end
          if (rd_last) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_npu_host_driver.sv
// tb_npu_host_driver: randomized transactions against a queue-based bus/result model of npu_host_driver
module tb_npu_host_driver;
  localparam int DW = 32;
  localparam int WCNT_W = 12;
  localparam int OUT_LAT = 2;
  localparam int WAIT_MAX = 16;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic [1:0] cfg_layers = '0;
  logic [4:0] cfg_in = '0, cfg_h1 = '0, cfg_h2 = '0, cfg_out = '0;
  logic cfg_act = 1'b0;
  logic [WCNT_W-1:0] cfg_num_w = '0;
  logic src_valid = 1'b0;
  logic [DW-1:0] src_data = '0;
  logic src_ready, npu_we, npu_oe, npu_data_oe;
  logic [DW-1:0] npu_data_o;
  logic [DW-1:0] npu_data_i = '0;
  logic npu_ready = 1'b0;
  logic res_valid, busy, done, err;
  logic [DW-1:0] res_data;
  logic [4:0] res_idx;
  npu_host_driver #(.DW(DW), .WCNT_W(WCNT_W), .OUT_LAT(OUT_LAT), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_layers(cfg_layers), .cfg_in(cfg_in), .cfg_h1(cfg_h1), .cfg_h2(cfg_h2),
    .cfg_out(cfg_out), .cfg_act(cfg_act), .cfg_num_w(cfg_num_w),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .npu_we(npu_we), .npu_oe(npu_oe), .npu_data_o(npu_data_o), .npu_data_oe(npu_data_oe),
    .npu_data_i(npu_data_i), .npu_ready(npu_ready),
    .res_valid(res_valid), .res_data(res_data), .res_idx(res_idx),
    .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  int n_tests = 0;
  int n_fail = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  logic [DW-1:0] wr_q[$];
  logic [DW-1:0] res_d_q[$];
  int res_i_q[$];
  logic [DW-1:0] rwords[32];
  logic [DW-1:0] last_drv;
  int cyc = 0, oe_cyc, done_cnt, wait_cyc, viol, start_cyc, first_we_cyc, last_rv_cyc, done_cyc;
  int oe_pos = 0;
  int c;
  // bus monitor plus NPU read-side model: word j appears OUT_LAT+j cycles into the npu_oe window
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      last_drv = '0;
    end else begin
      if (npu_we) begin
        wr_q.push_back(npu_data_o);
        if (first_we_cyc < 0) first_we_cyc = cyc;
        if (!npu_data_oe) viol++;
        last_drv = npu_data_o;
      end else if (npu_data_o !== last_drv) viol++;
      if (npu_oe && npu_data_oe) viol++;
      if (src_ready && !busy) viol++;
      if (start && !busy) start_cyc = cyc;
      if (busy && !npu_data_oe && !npu_oe) wait_cyc++;
      if (npu_oe) oe_cyc++;
      if (res_valid) begin
        res_d_q.push_back(res_data);
        res_i_q.push_back(int'(res_idx));
        last_rv_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
    if (rst && npu_oe) begin
      c = oe_pos;
      npu_data_i = (c >= OUT_LAT && c - OUT_LAT < 32) ? rwords[c - OUT_LAT] : $urandom;
      oe_pos = c + 1;
    end else begin
      oe_pos = 0;
      npu_data_i = $urandom;
    end
  end
  task automatic run_txn(input int mode, input logic [1:0] ly, input logic [4:0] ni, input logic [4:0] h1,
                         input logic [4:0] h2, input logic [4:0] no, input logic act, input int nw,
                         input int abort_at, input bit poke, input bit hang);
    logic [DW-1:0] exp_wr[$];
    int total, idx, k, t;
    bit acc, poked;
    total = nw + int'(ni) + 1;
    exp_wr.push_back(DW'(ly));
    exp_wr.push_back(DW'(ni));
    exp_wr.push_back(DW'(h1));
    exp_wr.push_back(DW'(h2));
    exp_wr.push_back(DW'(no));
    exp_wr.push_back(DW'(act));
    for (int i = 0; i < total; i++) exp_wr.push_back($urandom);
    for (int j = 0; j < 32; j++) rwords[j] = $urandom;
    wr_q.delete();
    res_d_q.delete();
    res_i_q.delete();
    oe_cyc = 0; done_cnt = 0; wait_cyc = 0; viol = 0;
    first_we_cyc = -1; start_cyc = -100; done_cyc = 0; last_rv_cyc = 0;
    @(posedge clk); #1;
    cfg_layers = ly; cfg_in = ni; cfg_h1 = h1; cfg_h2 = h2; cfg_out = no; cfg_act = act;
    cfg_num_w = WCNT_W'(nw);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("err_clr", err, 0);
    cfg_layers = 2'($urandom); cfg_in = 5'($urandom); cfg_h1 = 5'($urandom);
    cfg_h2 = 5'($urandom); cfg_out = 5'($urandom); cfg_act = 1'($urandom);
    cfg_num_w = WCNT_W'($urandom);
    idx = 0; k = 0; poked = 1'b0;
    while (idx < total && k < 2000) begin
      src_valid = mode == 1 ? (k % 3 != 2) : mode == 2 ? 1'($urandom_range(0, 1)) : 1'b1;
      src_data = exp_wr[6 + idx];
      start = poke && !poked && idx == nw + 1;
      if (start) poked = 1'b1;
      @(negedge clk);
      acc = src_valid && src_ready;
      if (abort_at >= 0 && idx == abort_at) begin
        #1 rst = 1'b0;
        #1 check("abort_outs", {npu_we, npu_oe, npu_data_oe, busy, src_ready}, 0);
        start = 1'b0;
        src_valid = 1'b0;
        @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        return;
      end
      @(posedge clk); #1;
      if (acc) idx++;
      k++;
    end
    start = 1'b0;
    src_valid = 1'b0;
    check("src_done", idx, total);
    check("wr_len", wr_q.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size(); i++)
      check($sformatf("wr[%0d]", i), i < wr_q.size() ? wr_q[i] : 'x, exp_wr[i]);
    if (hang) begin
      t = 0;
      while (busy && t < 300) begin
        @(posedge clk); #1;
        t++;
      end
      repeat (3) @(posedge clk);
      #1;
      check("to_busy", busy, 0);
      check("to_err", err, 1);
      check("to_wait_cyc", wait_cyc, WAIT_MAX);
      check("to_done", done_cnt, 0);
      check("to_oe", oe_cyc, 0);
      return;
    end
    repeat ($urandom_range(0, 3)) @(posedge clk);
    #1 npu_ready = 1'b1;
    t = 0;
    while (!npu_oe && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    npu_ready = 1'b0;
    t = 0;
    while (done_cnt == 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("res_len", res_d_q.size(), int'(no) + 1);
    for (int j = 0; j <= int'(no); j++) begin
      check($sformatf("res_data[%0d]", j), j < res_d_q.size() ? res_d_q[j] : 'x, rwords[j]);
      check($sformatf("res_idx[%0d]", j), j < res_i_q.size() ? res_i_q[j] : -1, j);
    end
    check("oe_cycles", oe_cyc, OUT_LAT + int'(no) + 1);
    check("done_cnt", done_cnt, 1);
    check("we_latency", first_we_cyc - start_cyc, 1);
    check("done_latency", done_cyc - last_rv_cyc, 1);
    check("bus_rules", viol, 0);
    check("err_low", err, 0);
    check("idle_after", busy, 0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("rst_ctrl", {src_ready, npu_we, npu_oe, npu_data_oe, res_valid, busy, done, err}, 0);
    check("rst_data", npu_data_o, 0);
    check("rst_res", {res_data, res_idx}, 0);
    @(posedge clk); #1 rst = 1'b1;
    run_txn(0, 2'd0, 5'd9, 5'd0, 5'd0, 5'd0, 1'b0, 11, -1, 1'b0, 1'b0);
    run_txn(1, 2'd0, 5'd9, 5'd0, 5'd0, 5'd0, 1'b0, 11, -1, 1'b0, 1'b0);
    run_txn(0, 2'd1, 5'd4, 5'd3, 5'd2, 5'd3, 1'b1, 7, -1, 1'b0, 1'b0);
    run_txn(0, 2'd2, 5'd3, 5'd1, 5'd1, 5'd1, 1'b0, 11, 5, 1'b0, 1'b0);
    run_txn(0, 2'd2, 5'd3, 5'd1, 5'd1, 5'd1, 1'b0, 11, -1, 1'b0, 1'b0);
    run_txn(2, 2'd3, 5'd5, 5'd6, 5'd7, 5'd2, 1'b1, 4, -1, 1'b1, 1'b0);
    run_txn(0, 2'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1, -1, 1'b0, 1'b0);
    for (int r = 0; r < 6; r++)
      run_txn(2, 2'($urandom), 5'($urandom_range(0, 7)), 5'($urandom), 5'($urandom),
              5'($urandom_range(0, 5)), 1'($urandom), $urandom_range(1, 16), -1, 1'b0, 1'b0);
`ifdef NPU_DRV_TIMEOUT_EN
    run_txn(0, 2'd1, 5'd2, 5'd1, 5'd1, 5'd1, 1'b0, 3, -1, 1'b0, 1'b1);
    run_txn(0, 2'd1, 5'd2, 5'd1, 5'd1, 5'd1, 1'b0, 3, -1, 1'b0, 1'b0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
